// File: rtl/bp_cfg_boot_sequencer.sv
// bp_cfg_boot_sequencer: boot-time config master that freezes all cores, loads CCE ucode, sets CCE mode, then unfreezes.
// Define BP_CFG_BOOT_SKIP_UCODE_EN to skip ucode loading and boot the CCEs in uncached mode.
module bp_cfg_boot_sequencer #(
   parameter int num_core_p = 2,
   parameter int cfg_core_width_p = 8,
   parameter int cfg_addr_width_p = 16,
   parameter int cfg_data_width_p = 32,
   parameter int num_cce_instr_ram_els_p = 256,
   parameter int cce_instr_width_p = 2 * cfg_data_width_p,
   localparam int core_w = (num_core_p > 1) ? $clog2(num_core_p) : 1,
   localparam int instr_w = (num_cce_instr_ram_els_p > 1) ? $clog2(num_cce_instr_ram_els_p) : 1
) (
   input  logic                         clk_i,
   input  logic                         reset_n_i,
   output logic                         cfg_v_o,
   input  logic                         cfg_ready_i,
   output logic [cfg_core_width_p-1:0]  cfg_core_o,
   output logic [cfg_addr_width_p-1:0]  cfg_addr_o,
   output logic [cfg_data_width_p-1:0]  cfg_data_o,
   output logic [instr_w-1:0]           rom_addr_o,
   input  logic [cce_instr_width_p-1:0] rom_data_i,
   output logic                         done_o
);
   typedef enum logic [2:0] {S_FREEZE, S_UC_RD, S_UC_LO, S_UC_HI, S_MODE, S_UNFREEZE, S_DONE} state_e;
   state_e state, state_n;
   logic [core_w-1:0] c, c_n;
   logic [instr_w-1:0] i, i_n;
   logic [cce_instr_width_p-1:0] hold;
   logic run, acc, last_c, last_i;
   logic [cfg_addr_width_p-1:0] wr_addr;
   logic [cfg_data_width_p-1:0] wr_data;
   assign acc = cfg_v_o & cfg_ready_i;
   assign last_c = c == core_w'(num_core_p - 1);
   assign last_i = i == instr_w'(num_cce_instr_ram_els_p - 1);
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= S_FREEZE;
         c <= '0;
         i <= '0;
         hold <= '0;
         run <= 1'b0;
      end else begin
         state <= state_n;
         c <= c_n;
         i <= i_n;
         run <= 1'b1;
         if (state == S_UC_RD) hold <= rom_data_i;
      end
   end
   // run holds off the first freeze write for one cycle so cfg_v_o leaves reset low
   always_comb begin
      state_n = state;
      c_n = c;
      i_n = i;
      cfg_v_o = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      case (state)
         S_FREEZE: begin
            cfg_v_o = run;
            wr_addr = cfg_addr_width_p'(16'h0001);
            wr_data = cfg_data_width_p'(1);
            if (acc) begin
               c_n = last_c ? '0 : c + core_w'(1);
`ifdef BP_CFG_BOOT_SKIP_UCODE_EN
               state_n = last_c ? S_MODE : S_FREEZE;
`else
               state_n = last_c ? S_UC_RD : S_FREEZE;
`endif
            end
         end
         S_UC_RD: state_n = S_UC_LO;
         S_UC_LO: begin
            cfg_v_o = 1'b1;
            wr_addr = cfg_addr_width_p'(16'h8000) + cfg_addr_width_p'({i, 1'b0});
            wr_data = hold[cfg_data_width_p-1:0];
            if (acc) state_n = S_UC_HI;
         end
         S_UC_HI: begin
            cfg_v_o = 1'b1;
            wr_addr = cfg_addr_width_p'(16'h8000) + cfg_addr_width_p'({i, 1'b1});
            wr_data = hold[2*cfg_data_width_p-1:cfg_data_width_p];
            if (acc) begin
               i_n = last_i ? '0 : i + instr_w'(1);
               c_n = !last_i ? c : (last_c ? '0 : c + core_w'(1));
               state_n = (last_i && last_c) ? S_MODE : S_UC_RD;
            end
         end
         S_MODE: begin
            cfg_v_o = 1'b1;
            wr_addr = cfg_addr_width_p'(16'h0002);
`ifdef BP_CFG_BOOT_SKIP_UCODE_EN
            wr_data = cfg_data_width_p'(1);
`else
            wr_data = '0;
`endif
            if (acc) begin
               c_n = last_c ? '0 : c + core_w'(1);
               state_n = last_c ? S_UNFREEZE : S_MODE;
            end
         end
         S_UNFREEZE: begin
            cfg_v_o = 1'b1;
            wr_addr = cfg_addr_width_p'(16'h0001);
            if (acc) begin
               c_n = last_c ? '0 : c + core_w'(1);
               state_n = last_c ? S_DONE : S_UNFREEZE;
            end
         end
         default: state_n = state;
      endcase
   end
   assign cfg_core_o = cfg_v_o ? cfg_core_width_p'(c) : '0;
   assign cfg_addr_o = cfg_v_o ? wr_addr : '0;
   assign cfg_data_o = cfg_v_o ? wr_data : '0;
   assign done_o = state == S_DONE;
`ifdef BP_CFG_BOOT_SKIP_UCODE_EN
   assign rom_addr_o = '0;
`else
   assign rom_addr_o = i;
`endif
endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// tb_bp_cfg_boot_sequencer: randomized self-checking bench for bp_cfg_boot_sequencer against a write-list model.
// Honours BP_CFG_BOOT_SKIP_UCODE_EN when it is defined for the build.
module tb_bp_cfg_boot_sequencer;
   typedef struct packed {
      logic [7:0]  core;
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;
   typedef wr_t wq_t[$];

`ifdef BP_CFG_BOOT_SKIP_UCODE_EN
   localparam int exp_cyc = 7;
   localparam logic [15:0] bp_addr = 16'h0002;
   localparam logic [15:0] mid_addr = 16'h0002;
`else
   localparam int exp_cyc = 31;
   localparam logic [15:0] bp_addr = 16'h8005;
   localparam logic [15:0] mid_addr = 16'h8002;
`endif

   logic clk = 0;
   logic reset_n, ready;
   logic v0, done0, v1, done1;
   logic [7:0] core0, core1;
   logic [15:0] addr0, addr1;
   logic [31:0] data0, data1;
   logic [1:0] ra0;
   logic [0:0] ra1;
   logic [63:0] rd0, rd1;
   logic [63:0] rom [4];
   int vectors, miscompares;
   wr_t log0[$], log1[$];
   logic st0;
   wr_t pw0;

   always #5 clk = ~clk;
   assign rd0 = rom[ra0];
   assign rd1 = rom[{1'b0, ra1}];

   bp_cfg_boot_sequencer #(.num_core_p(2), .cfg_core_width_p(8), .cfg_addr_width_p(16),
      .cfg_data_width_p(32), .num_cce_instr_ram_els_p(4), .cce_instr_width_p(64)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .cfg_v_o(v0), .cfg_ready_i(ready), .cfg_core_o(core0),
      .cfg_addr_o(addr0), .cfg_data_o(data0), .rom_addr_o(ra0), .rom_data_i(rd0), .done_o(done0));

   bp_cfg_boot_sequencer #(.num_core_p(1), .cfg_core_width_p(8), .cfg_addr_width_p(16),
      .cfg_data_width_p(32), .num_cce_instr_ram_els_p(1), .cce_instr_width_p(64)) dut1 (
      .clk_i(clk), .reset_n_i(reset_n), .cfg_v_o(v1), .cfg_ready_i(ready), .cfg_core_o(core1),
      .cfg_addr_o(addr1), .cfg_data_o(data1), .rom_addr_o(ra1), .rom_data_i(rd1), .done_o(done1));

   // Expected write list built straight from the boot sequence description
   function automatic wq_t build(input int nc, input int els);
      wq_t q;
      logic [31:0] md;
      for (int c = 0; c < nc; c++) q.push_back(wr_t'{8'(c), 16'h0001, 32'd1});
`ifdef BP_CFG_BOOT_SKIP_UCODE_EN
      md = 32'd1;
`else
      md = 32'd0;
      for (int c = 0; c < nc; c++)
         for (int k = 0; k < els; k++) begin
            q.push_back(wr_t'{8'(c), 16'(32'h8000 + 2 * k), rom[k][31:0]});
            q.push_back(wr_t'{8'(c), 16'(32'h8000 + 2 * k + 1), rom[k][63:32]});
         end
`endif
      for (int c = 0; c < nc; c++) q.push_back(wr_t'{8'(c), 16'h0002, md});
      for (int c = 0; c < nc; c++) q.push_back(wr_t'{8'(c), 16'h0001, 32'd0});
      return q;
   endfunction

   always @(negedge clk) begin
      if (!reset_n) st0 = 1'b0;
      else begin
         if (st0) begin
            vectors++;
            if (v0 !== 1'b1 || {core0, addr0, data0} !== pw0) begin
               miscompares++;
               $display("FAIL stall_hold: got v=%0b %h, want v=1 %h", v0, {core0, addr0, data0}, pw0);
            end
         end
         if (v0 && ready) log0.push_back({core0, addr0, data0});
         if (v1 && ready) log1.push_back({core1, addr1, data1});
         st0 = v0 && !ready;
         pw0 = {core0, addr0, data0};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 0;
      log0.delete();
      log1.delete();
      repeat (2) tick();
      reset_n = 1;
   endtask

   task automatic test_reset();
      reset_n = 0;
      repeat (2) tick();
      vectors++;
      if ({v0, core0, addr0, data0, ra0, done0} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: got %h, want 0", {v0, core0, addr0, data0, ra0, done0});
      end
      vectors++;
      if ({v1, core1, addr1, data1, ra1, done1} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs_1core: got %h, want 0", {v1, core1, addr1, data1, ra1, done1});
      end
   endtask

   task automatic test_full_sequence();
      wq_t e = build(2, 4);
      int cyc = 0;
      do_reset();
      ready = 1;
      while (!done0 && cyc < 200) begin
         tick();
         cyc++;
      end
      vectors++;
      if (cyc !== exp_cyc) begin
         miscompares++;
         $display("FAIL done_cycle: got %0d, want %0d", cyc, exp_cyc);
      end
      vectors++;
      if (log0.size() !== e.size()) begin
         miscompares++;
         $display("FAIL full_count: got %0d writes, want %0d", log0.size(), e.size());
      end
      for (int k = 0; k < e.size() && k < log0.size(); k++) begin
         vectors++;
         if (log0[k] !== e[k]) begin
            miscompares++;
            $display("FAIL full_write[%0d]: got %h, want %h", k, log0[k], e[k]);
         end
      end
      repeat (3) tick();
      vectors++;
      if ({done0, v0} !== 2'b10) begin
         miscompares++;
         $display("FAIL done_sticky: got done=%0b v=%0b, want done=1 v=0", done0, v0);
      end
   endtask

   task automatic test_single_core();
      wq_t e = build(1, 1);
      vectors++;
      if (done1 !== 1'b1) begin
         miscompares++;
         $display("FAIL single_done: got %0b, want 1", done1);
      end
      vectors++;
      if (log1.size() !== e.size()) begin
         miscompares++;
         $display("FAIL single_count: got %0d writes, want %0d", log1.size(), e.size());
      end
      for (int k = 0; k < e.size() && k < log1.size(); k++) begin
         vectors++;
         if (log1[k] !== e[k]) begin
            miscompares++;
            $display("FAIL single_write[%0d]: got %h, want %h", k, log1[k], e[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      wq_t e = build(2, 4);
      int n0, cyc = 0;
      logic found = 0;
      wr_t snap;
      do_reset();
      ready = 1;
      for (int k = 0; k < 200 && !found; k++) begin
         tick();
         found = v0 && core0 == 8'd0 && addr0 == bp_addr;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL bp_target: got none, want core0 addr %h", bp_addr);
      end
      ready = 0;
      snap = {core0, addr0, data0};
      n0 = log0.size();
      repeat (5) begin
         tick();
         vectors++;
         if (v0 !== 1'b1 || {core0, addr0, data0} !== snap || log0.size() !== n0) begin
            miscompares++;
            $display("FAIL bp_stall: got v=%0b %h n=%0d, want v=1 %h n=%0d", v0, {core0, addr0, data0}, log0.size(), snap, n0);
         end
      end
      ready = 1;
      tick();
      vectors++;
      if (log0.size() !== n0 + 1) begin
         miscompares++;
         $display("FAIL bp_accept: got %0d writes, want %0d", log0.size(), n0 + 1);
      end
`ifndef BP_CFG_BOOT_SKIP_UCODE_EN
      vectors++;
      if ({v0, ra0} !== 3'b011) begin
         miscompares++;
         $display("FAIL bp_resume: got v=%0b rom_addr=%0d, want v=0 rom_addr=3", v0, ra0);
      end
`endif
      while (!done0 && cyc < 200) begin
         tick();
         cyc++;
      end
      vectors++;
      if (log0 !== e) begin
         miscompares++;
         $display("FAIL bp_log: got %0d writes, want %0d matching model", log0.size(), e.size());
      end
   endtask

   task automatic test_random_ready();
      wq_t e = build(2, 4);
      int cyc = 0;
      do_reset();
      while (!done0 && cyc < 2000) begin
         ready = 1'($urandom_range(0, 1));
         tick();
         cyc++;
      end
      vectors++;
      if (done0 !== 1'b1) begin
         miscompares++;
         $display("FAIL rand_done: got %0b after %0d cycles, want 1", done0, cyc);
      end
      vectors++;
      if (log0.size() !== e.size()) begin
         miscompares++;
         $display("FAIL rand_count: got %0d writes, want %0d", log0.size(), e.size());
      end
      for (int k = 0; k < e.size() && k < log0.size(); k++) begin
         vectors++;
         if (log0[k] !== e[k]) begin
            miscompares++;
            $display("FAIL rand_write[%0d]: got %h, want %h", k, log0[k], e[k]);
         end
      end
      ready = 1;
   endtask

   task automatic test_reset_mid();
      wq_t e = build(2, 4);
      int cyc = 0;
      logic found = 0;
      do_reset();
      ready = 1;
      for (int k = 0; k < 200 && !found; k++) begin
         tick();
         found = v0 && core0 == 8'd1 && addr0 == mid_addr;
      end
      vectors++;
      if (!found) begin
         miscompares++;
         $display("FAIL mid_target: got none, want core1 addr %h", mid_addr);
      end
      #2 reset_n = 0;
      #1;
      vectors++;
      if ({v0, core0, addr0, data0, ra0, done0} !== '0) begin
         miscompares++;
         $display("FAIL mid_async_reset: got %h, want 0", {v0, core0, addr0, data0, ra0, done0});
      end
      log0.delete();
      repeat (2) tick();
      reset_n = 1;
      while (!done0 && cyc < 200) begin
         tick();
         cyc++;
      end
      vectors++;
      if (log0.size() == 0 || log0[0] !== wr_t'{8'd0, 16'h0001, 32'd1}) begin
         miscompares++;
         $display("FAIL mid_first_write: got %h, want %h", (log0.size() > 0) ? log0[0] : wr_t'('0), wr_t'{8'd0, 16'h0001, 32'd1});
      end
      vectors++;
      if (cyc !== exp_cyc || log0 !== e) begin
         miscompares++;
         $display("FAIL mid_restart: got %0d writes done at cycle %0d, want %0d at cycle %0d", log0.size(), cyc, e.size(), exp_cyc);
      end
   endtask

   initial begin
      ready = 1;
      reset_n = 0;
      vectors = 0;
      miscompares = 0;
      st0 = 0;
      pw0 = '0;
      foreach (rom[k]) rom[k] = {$urandom, $urandom};
      test_reset();
      test_full_sequence();
      test_single_core();
      test_backpressure();
      test_random_ready();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
